// File: rtl/cim_col_seq.sv
// Column sequencer for the 8-column CIM decoder: timed SETUP/PULSE/HOLD strobe per column.
// Optional abort port pair enabled by defining CIM_COL_SEQ_ABORT_EN.
module cim_col_seq #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [2:0] req_col,
    input  logic [2:0] req_ncol,
    input  logic [7:0] req_data,
    output logic       MAC_en,
    output logic [2:0] addr,
    output logic [7:0] data,
    output logic       wl_en,
    output logic       busy,
    output logic       done
`ifdef CIM_COL_SEQ_ABORT_EN
    ,
    input  logic       abort,
    output logic       aborted
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       rem_q;
    logic             abrt_q;
    logic             aborted_q;
    logic             mac_en_q;
    logic [2:0]       addr_q;
    logic [7:0]       data_q;
    logic             wl_en_q;
    logic             busy_q;
    logic             done_q;
    logic             abort_req;

`ifdef CIM_COL_SEQ_ABORT_EN
    assign abort_req = abort;
    assign aborted   = aborted_q;
`else
    logic unused_aborted;
    assign abort_req      = 1'b0;
    assign unused_aborted = aborted_q;
`endif

    assign cnt_d     = cnt_q - 1'b1;
    assign req_ready = (state_q == IDLE);
    assign MAC_en    = mac_en_q;
    assign addr      = addr_q;
    assign data      = data_q;
    assign wl_en     = wl_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            abrt_q    <= 1'b0;
            aborted_q <= 1'b0;
            mac_en_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wl_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q  <= SETUP;
                        cnt_q    <= SETUP_LD;
                        busy_q   <= 1'b1;
                        abrt_q   <= 1'b0;
                        mac_en_q <= req_op;
                        // MAC is a single pass at column 0; CAM sweeps from req_col.
                        rem_q    <= req_op ? 3'd0 : req_ncol;
                        addr_q   <= req_op ? 3'd0 : req_col;
                        data_q   <= req_op ? req_data : 8'd0;
                    end
                end
                SETUP: begin
                    if (abort_req) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LD;
                        abrt_q  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= PULSE;
                        cnt_q   <= PULSE_LD;
                        wl_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PULSE: begin
                    if (abort_req || cnt_q == '0) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LD;
                        wl_en_q <= 1'b0;
                        abrt_q  <= abort_req;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_d;
                    end else if (rem_q != 3'd0 && !abrt_q) begin
                        // Address wraps naturally in 3 bits (7 -> 0).
                        state_q <= SETUP;
                        cnt_q   <= SETUP_LD;
                        rem_q   <= rem_q - 3'd1;
                        addr_q  <= addr_q + 3'd1;
                    end else begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= abrt_q;
                        abrt_q    <= 1'b0;
                        mac_en_q  <= 1'b0;
                        addr_q    <= '0;
                        data_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_col_seq.sv
// Self-checking bench for cim_col_seq: per-cycle trace model plus directed literal checks.
module tb_cim_col_seq;

    localparam int S_A = 1, P_A = 2, H_A = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_valid_b;
    logic       req_ready, b_ready;
    logic       req_op;
    logic [2:0] req_col, req_ncol;
    logic [7:0] req_data;
    logic       mac_en, b_mac;
    logic [2:0] addr, b_addr;
    logic [7:0] data, b_data;
    logic       wl_en, b_wl;
    logic       busy, b_busy;
    logic       done, b_done;
    logic       abort;
    logic       aborted, b_aborted;

    int tests = 0;
    int fails = 0;
    bit model_off = 1'b0;

    always #5 clk = ~clk;

    cim_col_seq #(.SETUP_CYC(S_A), .PULSE_CYC(P_A), .HOLD_CYC(H_A), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_col(req_col), .req_ncol(req_ncol), .req_data(req_data),
        .MAC_en(mac_en), .addr(addr), .data(data), .wl_en(wl_en), .busy(busy), .done(done)
`ifdef CIM_COL_SEQ_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    cim_col_seq #(.SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(b_ready),
        .req_op(req_op), .req_col(req_col), .req_ncol(req_ncol), .req_data(req_data),
        .MAC_en(b_mac), .addr(b_addr), .data(b_data), .wl_en(b_wl), .busy(b_busy), .done(b_done)
`ifdef CIM_COL_SEQ_ABORT_EN
        , .abort(1'b0), .aborted(b_aborted)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs, one entry per cycle following an accept edge.
    typedef struct packed {
        logic       wl;
        logic       mac;
        logic       busy;
        logic       done;
        logic [2:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];

    task automatic push_op(input logic op, input logic [2:0] col, input logic [2:0] ncol,
                           input logic [7:0] dat);
        int   n;
        exp_t e;
        n = op ? 1 : int'(ncol) + 1;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < S_A + P_A + H_A; c++) begin
                e.wl   = (c >= S_A) && (c < S_A + P_A);
                e.mac  = op;
                e.busy = 1'b1;
                e.done = 1'b0;
                e.addr = op ? 3'd0 : 3'(int'(col) + p);
                e.data = op ? dat : 8'd0;
                q.push_back(e);
            end
        end
        e = '0;
        e.done = 1'b1;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t cur;
        if (!rst_n || model_off) begin
            q.delete();
        end else begin
            cur = (q.size() != 0) ? q.pop_front() : exp_t'(0);
            chk("m_ready", req_ready, !cur.busy);
            chk("m_wl_en", wl_en, cur.wl);
            chk("m_mac_en", mac_en, cur.mac);
            chk("m_busy", busy, cur.busy);
            chk("m_done", done, cur.done);
            chk("m_addr", addr, cur.addr);
            chk("m_data", data, cur.data);
            if (req_valid && !cur.busy) push_op(req_op, req_col, req_ncol, req_data);
        end
    end

    // Raise a request, wait for the handshake, drop valid just after the accept edge.
    task automatic send(input bit sel, input logic op, input logic [2:0] col,
                        input logic [2:0] ncol, input logic [7:0] dat);
        bit ok = 1'b0;
        req_op = op; req_col = col; req_ncol = ncol; req_data = dat;
        if (sel) req_valid_b = 1'b1; else req_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((sel ? b_ready : req_ready) == 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_valid_b = 1'b0;
    endtask

    int         m_done, m_wl, m_pulses, m_first_wl, m_mac;
    logic [2:0] m_addr [8];

    // Called right after an accept edge; cycle i is the i-th cycle after it.
    task automatic measure(input bit sel, input int max_cyc);
        logic prev = 1'b0, w;
        m_done = -1; m_wl = 0; m_pulses = 0; m_first_wl = -1; m_mac = 0;
        for (int i = 0; i < 8; i++) m_addr[i] = 3'd0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            w = sel ? b_wl : wl_en;
            if (w) begin
                m_wl++;
                if (m_first_wl < 0) m_first_wl = i;
                if (!prev && m_pulses < 8) begin
                    m_addr[m_pulses] = sel ? b_addr : addr;
                    m_pulses++;
                end
            end
            prev = w;
            if (sel ? b_mac : mac_en) m_mac++;
            if (sel ? b_done : done) begin m_done = i; break; end
        end
    endtask

    initial begin
        int  wait_cyc;
        bit  seen;
        rst_n = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0; abort = 1'b0;
        req_op = 1'b0; req_col = 3'd0; req_ncol = 3'd0; req_data = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wl", wl_en, 0);
        chk("rst_done", done, 0);

        // MAC single pass
        send(1'b0, 1'b1, 3'd5, 3'd7, 8'hA5);
        measure(1'b0, 40);
        chk("mac_done_cyc", m_done, 5);
        chk("mac_wl_cycles", m_wl, 2);
        chk("mac_wl_first", m_first_wl, 2);
        chk("mac_en_cycles", m_mac, 4);
        repeat (2) @(negedge clk);

        // CAM sweep with address wrap
        send(1'b0, 1'b0, 3'd6, 3'd3, 8'hFF);
        measure(1'b0, 60);
        chk("cam_done_cyc", m_done, 17);
        chk("cam_pulses", m_pulses, 4);
        chk("cam_wl_cycles", m_wl, 8);
        chk("cam_mac_cycles", m_mac, 0);
        chk("cam_addr0", m_addr[0], 6);
        chk("cam_addr1", m_addr[1], 7);
        chk("cam_addr2", m_addr[2], 0);
        chk("cam_addr3", m_addr[3], 1);
        repeat (2) @(negedge clk);

        // Back-to-back: second request held through the first op
        send(1'b0, 1'b1, 3'd0, 3'd0, 8'h3C);
        req_op = 1'b0; req_col = 3'd2; req_ncol = 3'd0; req_data = 8'h00;
        req_valid = 1'b1;
        wait_cyc = -1;
        seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (req_ready) begin wait_cyc = i; seen = done; break; end
        end
        chk("b2b_accept_cyc", wait_cyc, 5);
        chk("b2b_done_at_accept", seen, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_setup_busy", busy, 1);
        chk("b2b_setup_addr", addr, 2);
        chk("b2b_setup_wl", wl_en, 0);
        repeat (6) @(negedge clk);

        // Parameter sweep on the second instance
        send(1'b1, 1'b0, 3'd5, 3'd0, 8'h00);
        measure(1'b1, 40);
        chk("psw_done_cyc", m_done, 7);
        chk("psw_wl_cycles", m_wl, 1);
        chk("psw_pulses", m_pulses, 1);
        chk("psw_first_wl", m_first_wl, 3);
        chk("psw_addr", m_addr[0], 5);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a PULSE
        send(1'b0, 1'b0, 3'd3, 3'd2, 8'h00);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_wl", wl_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mac", mac_en, 0);
        chk("arst_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", req_ready, 1);
        chk("arst_addr", addr, 0);
        repeat (2) @(negedge clk);

`ifdef CIM_COL_SEQ_ABORT_EN
        model_off = 1'b1;
        send(1'b0, 1'b0, 3'd0, 3'd3, 8'h00);
        @(negedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("ab_wl_pulse", wl_en, 1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("ab_wl_drop", wl_en, 0);
        chk("ab_hold_busy", busy, 1);
        @(negedge clk);
        chk("ab_done", done, 1);
        chk("ab_aborted", aborted, 1);
        chk("ab_busy_end", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wl_en || aborted) seen = 1'b1;
        end
        chk("ab_no_more_strobe", seen, 0);
        model_off = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
